// File: rtl/std_sram_singleport_requester.sv
// Single-port SRAM requester: forwards valid/ready requests straight onto the
// SRAM pins and collects read data into a credit-protected response FIFO.
// A credit counter covers reads in flight plus FIFO occupancy. Every accepted
// read is therefore guaranteed a FIFO slot when its data returns.
module std_sram_singleport_requester #(
  parameter int ADDR_WIDTH   = 1,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]           credit_q, credit_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wrPtr_q, rdPtr_q;
  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0]   mem_q [RSP_DEPTH];

  logic rdAccept;
  logic push;
  logic pop;
  logic full;

  // req_ready depends only on the registered credit count and reset, so
  // downstream rsp_ready can never reach it combinationally.
  assign req_ready = (credit_q < DEPTH_C) & ~areset;

  // The request goes straight onto the SRAM pins in the handshake cycle.
  assign sram_en   = req_valid & req_ready;
  assign sram_we   = req_we;
  assign sram_addr = req_addr;
  assign sram_din  = req_wdata;

  assign rdAccept  = sram_en & ~req_we;
  assign push      = valid_q[READ_LATENCY-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (count_q == DEPTH_C);
  assign rsp_rdata = mem_q[rdPtr_q];

  // Next credit and occupancy: a simultaneous increment and decrement cancel out.
  always_comb begin
    credit_d = credit_q;
    count_d  = count_q;
    if (rdAccept && !pop) begin
      credit_d = credit_q + 1'b1;
    end else if (!rdAccept && pop) begin
      credit_d = credit_q - 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state. Reset drops all in-flight reads and empties the FIFO.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      credit_q <= '0;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      valid_q  <= '0;
    end else begin
      credit_q   <= credit_d;
      count_q    <= count_d;
      valid_q[0] <= rdAccept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      if (push) begin
        wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
      end
    end
  end

  // FIFO storage has no reset. Its contents are ignored whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= sram_dout;
    end
  end

  // The credit gate should make a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (!areset) begin
      assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_std_sram_singleport_requester.sv
// Testbench for std_sram_singleport_requester (ADDR 4, DATA 8, latency 2, depth 4).
// Reference model: a queue of outstanding reads, each with the cycle its data
// becomes visible, plus a shadow copy of the SRAM contents.
module tb_std_sram_singleport_requester;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk;
  logic          areset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  std_sram_singleport_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .RSP_DEPTH(DEP)
  ) dut (
    .clk(clk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous read with a two-stage output pipe.
  logic [DW-1:0] sramMem [16];
  logic [DW-1:0] rdPipe0, rdPipe1;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sramMem[sram_addr] <= sram_din;
      else         rdPipe0 <= sramMem[sram_addr];
    end
    rdPipe1 <= rdPipe0;
  end
  assign sram_dout = rdPipe1;

  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  rsp_t          expQ[$];
  logic [DW-1:0] modelMem [16];
  int            cycle = 0;
  int            compared = 0;
  int            mismatched = 0;

  // One comparison: count it, and report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Check one cycle on the falling edge, advance the model, then move past the rising edge.
  task automatic tick();
    logic expReady, expValid, acc;
    rsp_t e;
    @(negedge clk);
    expReady = !areset && (expQ.size() < DEP);
    expValid = !areset && (expQ.size() > 0) && (expQ[0].vis <= cycle);
    acc      = req_valid && expReady;
    checkOutput("req_ready", {31'd0, req_ready}, {31'd0, expReady});
    checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, expValid});
    if (expValid) checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, expQ[0].data});
    checkOutput("sram_en", {31'd0, sram_en}, {31'd0, acc});
    if (acc) begin
      checkOutput("sram_we", {31'd0, sram_we}, {31'd0, req_we});
      checkOutput("sram_addr", {28'd0, sram_addr}, {28'd0, req_addr});
      if (req_we) checkOutput("sram_din", {24'd0, sram_din}, {24'd0, req_wdata});
    end
    if (areset) begin
      expQ.delete();
    end else begin
      if (expValid && rsp_ready) void'(expQ.pop_front());
      if (acc) begin
        if (req_we) begin
          modelMem[req_addr] = req_wdata;
        end else begin
          e.data = modelMem[req_addr];
          e.vis  = cycle + LAT + 1;
          expQ.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Drive one cycle of inputs, then check that cycle.
  task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    tick();
  endtask

  initial begin
    areset    = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state: nothing ready or valid, and no SRAM access even with req_valid high.
    tick();
    tick();
    areset = 1'b0;

    // Write 0xA5 to addr 3, accepted in the first cycle after reset release, then read it back.
    applyStimulus(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    #2;
    checkOutput("r030_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("r030_data", {24'd0, rsp_rdata}, 32'hA5);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    // Fill every address with back-to-back writes; no responses should appear.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0);
    end

    // Five reads with the consumer stalled: the first four are accepted.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, AW'(i), 8'h00, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 4'd4, 8'h00, 1'b0);
    end

    // FIFO full: one pop; the pending read is accepted only on the following cycle.
    applyStimulus(1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd4, 8'h00, 1'b0);

    // Credits exhausted: writes are blocked as well.
    applyStimulus(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);

    // Drain the FIFO in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    end

    // Reset mid-cycle with one response visible and two reads still in flight.
    applyStimulus(1'b1, 1'b0, 4'd6, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd8, 8'h00, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    #1;
    checkOutput("pre_reset_valid", {31'd0, rsp_valid}, 32'd1);
    #1;
    areset = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset_sram_en", {31'd0, sram_en}, 32'd0);
    expQ.delete();
    tick();
    tick();
    areset = 1'b0;

    // After release: discarded reads never show up, then a fresh read works.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 4'd9, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    end

    // Random traffic (mostly reads) with the consumer alternating between ready and stalled.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    AW'($urandom_range(0, 15)), DW'($urandom), (i % 2) == 0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/std_sram_singleport_requester.md
STD_SRAM_SINGLEPORT_REQUESTER -- requirements
Module: std_sram_singleport_requester

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 1, SRAM address width; DATA_WIDTH, default 1, SRAM data width; READ_LATENCY, default 1, cycles from SRAM read issue to valid sram_dout (legal 1..3); RSP_DEPTH, default 4, response FIFO entries (legal READ_LATENCY..16).
REQ-002 SHALL have one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 SHALL have: areset  in  1  asynchronous active-high reset.
REQ-004 SHALL have: req_valid  in  1  request offered.
REQ-005 SHALL have: req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have: req_we  in  1  1=write, 0=read.
REQ-007 SHALL have: req_addr  in  ADDR_WIDTH  request address.
REQ-008 SHALL have: req_wdata  in  DATA_WIDTH  write data.
REQ-009 SHALL have: rsp_valid  out  1  read data available.
REQ-010 SHALL have: rsp_ready  in  1  consumer takes read data.
REQ-011 SHALL have: rsp_rdata  out  DATA_WIDTH  read data, FIFO head.
REQ-012 SHALL have: sram_en, sram_we  out  1 each; sram_addr  out  ADDR_WIDTH; sram_din  out  DATA_WIDTH; sram_dout  in  DATA_WIDTH; these drive a single-port SRAM.

Function
REQ-013 SHALL issue on handshake: sram_en = req_valid & req_ready, sram_we = req_we, sram_addr = req_addr, sram_din = req_wdata, all combinational, zero added latency.
REQ-014 SHALL keep a credit counter C = reads in flight + FIFO occupancy, width clog2(RSP_DEPTH+1), reset 0.
REQ-015 SHALL drive req_ready = (C < RSP_DEPTH) & ~areset, from registered state only; no combinational path from req_valid, req_we or rsp_ready.
REQ-016 SHALL apply the credit gate to writes as well as reads.
REQ-017 SHALL increment C on an accepted read, decrement on a response pop (rsp_valid & rsp_ready), and leave C unchanged when both occur in one cycle.
REQ-018 SHALL leave C unchanged on accepted writes; writes produce no response.
REQ-019 SHALL track reads in a READ_LATENCY-stage valid shift register, one bit entered per cycle (1 on accepted read, else 0).
REQ-020 SHALL push sram_dout into the response FIFO in the cycle the last shift stage is valid.
REQ-021 SHALL implement the FIFO as RSP_DEPTH entries with wrapping read/write pointers; rsp_valid = FIFO non-empty; rsp_rdata = head entry, registered storage.
REQ-022 SHALL allow push and pop in the same cycle, including when full or when holding one entry; occupancy stays unchanged and order is preserved.
REQ-023 SHALL never overflow the FIFO; the credit invariant guarantees this. An assertion SHALL flag a push when full.
REQ-024 SHALL deliver responses strictly in read-issue order; first rsp_valid exactly READ_LATENCY+1 cycles after issue with an empty FIFO (push at latency edge, visible next cycle).
REQ-025 SHALL hold rsp_rdata stable while rsp_valid & ~rsp_ready.

Reset
REQ-026 SHALL, while areset is high, clear C, the shift register, and the FIFO pointers/occupancy asynchronously; rsp_valid=0, req_ready=0, sram_en=0.
REQ-027 SHALL discard reads in flight at reset; no response for them appears after reset release.
REQ-028 SHALL not reset FIFO data storage; rsp_rdata is don't-care while rsp_valid=0.
REQ-029 SHALL allow a request to be accepted in the first cycle after areset deasserts.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, READ_LATENCY=2, RSP_DEPTH=4, behavioural SRAM model)
REQ-030 SHALL check: write 0xA5 to addr 3, then read addr 3 -> one sram_en pulse each with correct sram_we; rsp_valid high 3 cycles after read issue, rsp_rdata=0xA5.
REQ-031 SHALL check: rsp_ready=0, 5 back-to-back reads of addrs 0..4 -> first 4 accepted, req_ready=0 from the cycle after the 4th; after rsp_ready=1, data for addrs 0..3 appears in order.
REQ-032 SHALL check: FIFO full (C=4), rsp_ready=1 with a pending read -> req_ready rises one cycle after the pop, never in the same cycle; the read is accepted and C returns to 4.
REQ-033 SHALL check: 3 writes while C=0 -> all accepted back-to-back, rsp_valid stays 0, C stays 0; with C=4 a write sees req_ready=0.
REQ-034 SHALL check: 2 reads in flight, assert areset mid-cycle -> rsp_valid and req_ready drop immediately; after release no rsp_valid without a new read.
REQ-035 SHALL check: continuous reads with rsp_ready toggling 1010... -> no data loss, no duplication, in-order data, C never exceeds 4.
